// File: rtl/frac_interp_pkg.sv
// ---------------------------------------------------------------------------
// frac_interp_pkg
//   Shared definitions for the fractional-position interpolator.
//   - Default width constants for the read position and sample format.
//   - FSM state encoding used by frac_interp.
// ---------------------------------------------------------------------------
package frac_interp_pkg;

    // Integer bits of the read position; also the sample buffer address width.
    localparam int INT_WIDTH  = 11;
    // Fraction bits of the read position.
    localparam int FRAC_WIDTH = 21;
    // Signed two's-complement sample width.
    localparam int DATA_WIDTH = 16;

    // Sequencer states: two buffer reads, one compute cycle, one hand-off state.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CALC = 3'd3,
        OUT  = 3'd4
    } state_e;

endpackage : frac_interp_pkg

// File: rtl/frac_interp_lerp_datapath.sv
// ---------------------------------------------------------------------------
// lerp_datapath
//   Purely combinational linear interpolation between two signed samples:
//     result = s0 + round((s1 - s0) * frac / 2^FRAC_WIDTH)
//   Rounding is half toward +infinity (add one half, arithmetic shift).
//   Because |frac| < 1 the result always lies between s0 and s1, so the
//   final truncation to DATA_WIDTH never loses information.
//
// Ports
//   s0      in   DATA_WIDTH   signed sample at the integer position
//   s1      in   DATA_WIDTH   signed sample at the next position
//   frac    in   FRAC_WIDTH   unsigned fraction of the read position
//   result  out  DATA_WIDTH   signed interpolated sample
// ---------------------------------------------------------------------------
module lerp_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 21
) (
    input  logic signed [DATA_WIDTH-1:0] s0,
    input  logic signed [DATA_WIDTH-1:0] s1,
    input  logic        [FRAC_WIDTH-1:0] frac,
    output logic signed [DATA_WIDTH-1:0] result
);

    // Working width: (DATA_WIDTH+1)-bit difference times a FRAC_WIDTH-bit
    // non-negative fraction, plus one guard bit for the rounding add.
    localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;

    // One half LSB of the output, expressed in product units.
    localparam logic signed [PW-1:0] HALF =
        {{(PW-FRAC_WIDTH){1'b0}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]       diff_ext;
    logic signed [PW-1:0]       frac_ext;
    logic signed [PW-1:0]       s0_ext;
    logic signed [PW-1:0]       prod;

    always_comb begin
        // One extra bit so that s1 - s0 never overflows.
        diff     = {s1[DATA_WIDTH-1], s1} - {s0[DATA_WIDTH-1], s0};
        diff_ext = {{(PW-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff};
        // Fraction is unsigned: zero-extend so it stays non-negative.
        frac_ext = {{(PW-FRAC_WIDTH){1'b0}}, frac};
        s0_ext   = {{(PW-DATA_WIDTH){s0[DATA_WIDTH-1]}}, s0};
        prod     = diff_ext * frac_ext;
        // Arithmetic shift floors, so adding HALF first rounds half up.
        result   = DATA_WIDTH'(s0_ext + ((prod + HALF) >>> FRAC_WIDTH));
    end

endmodule : lerp_datapath

// File: rtl/frac_interp.sv
// ---------------------------------------------------------------------------
// frac_interp
//   Evaluates a sample buffer at a fractional read position by fetching the
//   two neighbouring samples from an external synchronous-read buffer and
//   linearly interpolating between them.
//
//   Flow per position: IDLE/OUT accept -> RD0 (read s0) -> RD1 (read s1,
//   capture s0) -> CALC (capture s1, register result) -> OUT (present).
//   A new position may be accepted in OUT in the same cycle the current
//   sample is handed off, giving one sample every four cycles.
//
// Ports
//   clk           in   1                     clock, rising edge
//   reset_n       in   1                     async assert, active-low reset
//   pos_in        in   INT_WIDTH+FRAC_WIDTH  read position {integer, fraction}
//   pos_valid     in   1                     pos_in valid
//   pos_ready     out  1                     position accepted this cycle
//   mem_addr      out  INT_WIDTH             buffer read address (0 when idle)
//   mem_en        out  1                     buffer read strobe (1-cycle latency)
//   mem_data      in   DATA_WIDTH            signed buffer read data
//   sample_out    out  DATA_WIDTH            signed interpolated sample
//   sample_valid  out  1                     sample_out valid
//   sample_ready  in   1                     downstream accepts sample_out
// ---------------------------------------------------------------------------
module frac_interp #(
    parameter int INT_WIDTH  = frac_interp_pkg::INT_WIDTH,
    parameter int FRAC_WIDTH = frac_interp_pkg::FRAC_WIDTH,
    parameter int DATA_WIDTH = frac_interp_pkg::DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0] pos_in,
    input  logic                            pos_valid,
    output logic                            pos_ready,
    output logic [INT_WIDTH-1:0]            mem_addr,
    output logic                            mem_en,
    input  logic signed [DATA_WIDTH-1:0]    mem_data,
    output logic signed [DATA_WIDTH-1:0]    sample_out,
    output logic                            sample_valid,
    input  logic                            sample_ready
);

    import frac_interp_pkg::*;

    localparam int PWIDTH = INT_WIDTH + FRAC_WIDTH;

    state_e                        state_q, state_d;
    logic [PWIDTH-1:0]             pos_q, pos_d;
    logic signed [DATA_WIDTH-1:0]  s0_q, s0_d;
    logic signed [DATA_WIDTH-1:0]  s1_q, s1_d;
    logic signed [DATA_WIDTH-1:0]  sample_out_q, sample_out_d;
    logic                          sample_valid_q, sample_valid_d;
    logic                          mem_en_q, mem_en_d;
    logic [INT_WIDTH-1:0]          mem_addr_q, mem_addr_d;
    // Held low through reset and set by the first clock edge afterwards, so
    // pos_ready is 0 during reset and rises on the first edge after release.
    logic                          run_q;

    logic                          accept;
    logic signed [DATA_WIDTH-1:0]  lerp_s1;
    logic signed [DATA_WIDTH-1:0]  lerp_result;

    // -----------------------------------------------------------------------
    // Datapath. s1 arrives on mem_data during CALC; outside CALC the
    // datapath sees the captured s1 register so its output depends only on
    // registered state.
    // -----------------------------------------------------------------------
    assign lerp_s1 = (state_q == CALC) ? mem_data : s1_q;

    lerp_datapath #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_lerp (
        .s0     (s0_q),
        .s1     (lerp_s1),
        .frac   (pos_q[FRAC_WIDTH-1:0]),
        .result (lerp_result)
    );

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign pos_ready = run_q && ((state_q == IDLE) ||
                                 ((state_q == OUT) && sample_ready));
    assign accept    = pos_valid && pos_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sample_out_d   = sample_out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RD0;
                    pos_d   = pos_in;
                end
            end
            RD0: begin
                state_d = RD1;
            end
            RD1: begin
                // Data for the RD0 read is on mem_data now.
                s0_d    = mem_data;
                state_d = CALC;
            end
            CALC: begin
                s1_d         = mem_data;
                sample_out_d = lerp_result;
                state_d      = OUT;
            end
            OUT: begin
                // sample_out_q is untouched here, so it holds under back
                // pressure and the handed-off value is never overwritten
                // before CALC of the next position.
                if (sample_ready) begin
                    if (pos_valid) begin
                        state_d = RD0;
                        pos_d   = pos_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they belong to.
        sample_valid_d = (state_d == OUT);
        mem_en_d       = (state_d == RD0) || (state_d == RD1);
        if (state_d == RD0) begin
            mem_addr_d = pos_d[FRAC_WIDTH +: INT_WIDTH];
        end else if (state_d == RD1) begin
            // Natural INT_WIDTH overflow gives the modulo wrap to address 0.
            mem_addr_d = pos_q[FRAC_WIDTH +: INT_WIDTH]
                       + {{(INT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mem_addr_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pos_q          <= '0;
            s0_q           <= '0;
            s1_q           <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_addr_q     <= '0;
            run_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            mem_en_q       <= mem_en_d;
            mem_addr_q     <= mem_addr_d;
            run_q          <= 1'b1;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign mem_en       = mem_en_q;
    assign mem_addr     = mem_addr_q;

endmodule : frac_interp

// File: tb/tb_frac_interp.sv
// ---------------------------------------------------------------------------
// tb_frac_interp
//   Self-checking bench for frac_interp. A behavioural buffer model answers
//   reads one cycle after mem_en; expected samples come from a reference
//   function that evaluates s0 + round-half-up((s1-s0)*f) with integer
//   division. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_frac_interp;

    localparam int IW = 11;
    localparam int FW = 21;
    localparam int DW = 16;
    localparam int DEPTH = 1 << IW;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [IW+FW-1:0]       pos_in;
    logic                   pos_valid;
    logic                   pos_ready;
    logic [IW-1:0]          mem_addr;
    logic                   mem_en;
    logic signed [DW-1:0]   mem_data;
    logic signed [DW-1:0]   sample_out;
    logic                   sample_valid;
    logic                   sample_ready;

    logic signed [DW-1:0]   mem_model [0:DEPTH-1];
    int                     addr_log [$];
    int                     checks = 0;
    int                     errors = 0;

    always #5 clk = ~clk;

    frac_interp dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pos_in       (pos_in),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .mem_addr     (mem_addr),
        .mem_en       (mem_en),
        .mem_data     (mem_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    // Synchronous-read buffer; junk when not enabled so stray use shows up.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_data <= mem_model[mem_addr];
            addr_log.push_back(int'(mem_addr));
        end else begin
            mem_data <= DW'($urandom);
        end
    end

    // Address must be parked at 0 whenever no read is issued.
    always @(negedge clk) begin
        checks++;
        if (!mem_en && mem_addr !== '0) begin
            errors++;
            $display("FAIL addr_idle: mem_addr=%0d required 0", mem_addr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: out = s0 + floor((s1-s0)*F/2^FW + 1/2), truncated to DW.
    function automatic logic signed [DW-1:0] model(input int s0, input int s1,
                                                   input longint frac);
        longint den, num, r;
        den = longint'(1) << FW;
        num = longint'(s1 - s0) * frac + den / 2;
        if (num >= 0) r = num / den;
        else          r = -((-num + den - 1) / den);
        return DW'(longint'(s0) + r);
    endfunction

    function automatic logic [IW+FW-1:0] mkpos(input int i, input int f);
        return {IW'(i), FW'(f)};
    endfunction

    // Present one position for one cycle (caller has confirmed pos_ready).
    task automatic start_pos(input logic [IW+FW-1:0] p);
        pos_in    = p;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
    endtask

    // Count falling edges until sample_valid, bounded by limit.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!sample_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pos_valid    = 1'b0;
        sample_ready = 1'b0;
        pos_in       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pos_ready, sample_valid, mem_en} !== 3'b000 ||
            sample_out !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b en=%b out=%0d addr=%0d required all 0",
                     pos_ready, sample_valid, mem_en, sample_out, mem_addr);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (pos_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready_early: pos_ready=%b required 0", pos_ready);
        end
        @(negedge clk);
        checks++;
        if (pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: pos_ready=%b required 1", pos_ready);
        end
        $display("reset: done");
    endtask

    task automatic test_frac_zero();
        int n;
        mem_model[5] = 16'sd100;
        mem_model[6] = 16'sd200;
        sample_ready = 1'b1;
        addr_log.delete();
        start_pos(mkpos(5, 0));
        wait_valid(10, n);
        checks++;
        if (n + 1 != 4) begin
            errors++;
            $display("FAIL frac_zero_latency: cycles=%0d required 4", n + 1);
        end
        checks++;
        if (sample_out !== 16'sd100) begin
            errors++;
            $display("FAIL frac_zero_value: sample_out=%0d required 100", sample_out);
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] != 5 || addr_log[1] != 6) begin
            errors++;
            $display("FAIL frac_zero_addrs: reads=%p required 5,6", addr_log);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL frac_zero_handoff: sample_valid=%b required 0", sample_valid);
        end
        $display("frac_zero: pos=5.0 out=100 latency=%0d", n + 1);
    endtask

    task automatic test_half();
        int s0s [3] = '{0, 1, -100};
        int s1s [3] = '{1, 0, 100};
        int exps[3] = '{1, 1, 0};
        int n;
        sample_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_model[5] = DW'(s0s[k]);
            mem_model[6] = DW'(s1s[k]);
            start_pos(mkpos(5, 1 << (FW - 1)));
            wait_valid(10, n);
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== DW'(exps[k])) begin
                errors++;
                $display("FAIL half_%0d: valid=%b sample_out=%0d required %0d",
                         k, sample_valid, sample_out, exps[k]);
            end
            $display("half: s0=%0d s1=%0d out=%0d", s0s[k], s1s[k], sample_out);
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int n;
        mem_model[DEPTH-1] = -16'sd32768;
        mem_model[0]       = 16'sd32767;
        sample_ready = 1'b1;
        addr_log.delete();
        start_pos(mkpos(DEPTH - 1, 1 << (FW - 2)));
        wait_valid(10, n);
        checks++;
        if (addr_log.size() != 2 || addr_log[0] != DEPTH - 1 || addr_log[1] != 0) begin
            errors++;
            $display("FAIL wrap_addrs: reads=%p required 2047,0", addr_log);
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== -16'sd16384) begin
            errors++;
            $display("FAIL wrap_value: valid=%b sample_out=%0d required -16384",
                     sample_valid, sample_out);
        end
        $display("wrap: pos=2047.25 out=%0d", sample_out);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        logic signed [DW-1:0] exp1, exp2;
        mem_model[10] = 16'sd1000;
        mem_model[11] = -16'sd1000;
        mem_model[20] = 16'sd7;
        mem_model[21] = 16'sd8;
        exp1 = model(1000, -1000, longint'(3) << (FW - 2));
        exp2 = model(7, 8, longint'(1) << (FW - 1));
        sample_ready = 1'b0;
        start_pos(mkpos(10, 3 << (FW - 2)));
        wait_valid(10, n);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== exp1 || pos_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b out=%0d ready=%b required 1,%0d,0",
                         c, sample_valid, sample_out, pos_ready, exp1);
            end
            @(negedge clk);
        end
        sample_ready = 1'b1;
        pos_in       = mkpos(20, 1 << (FW - 1));
        pos_valid    = 1'b1;
        #1;
        checks++;
        if (pos_ready !== 1'b1 || sample_valid !== 1'b1 || sample_out !== exp1) begin
            errors++;
            $display("FAIL b2b_handoff: ready=%b valid=%b out=%0d required 1,1,%0d",
                     pos_ready, sample_valid, sample_out, exp1);
        end
        @(negedge clk);
        pos_valid = 1'b0;
        checks++;
        if (sample_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== IW'(20)) begin
            errors++;
            $display("FAIL b2b_rd0: valid=%b en=%b addr=%0d required 0,1,20",
                     sample_valid, mem_en, mem_addr);
        end
        wait_valid(10, n);
        checks++;
        if (n + 1 != 4 || sample_out !== exp2) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d out=%0d required 4,%0d", n + 1, sample_out, exp2);
        end
        $display("back_to_back: out1=%0d out2=%0d", exp1, sample_out);
        @(negedge clk);
    endtask

    task automatic test_abort();
        mem_model[30] = 16'sd500;
        mem_model[31] = 16'sd600;
        sample_ready = 1'b1;
        start_pos(mkpos(30, 1 << (FW - 1)));
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== IW'(31)) begin
            errors++;
            $display("FAIL abort_rd1: en=%b addr=%0d required 1,31", mem_en, mem_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pos_ready, sample_valid, mem_en} !== 3'b000 ||
            sample_out !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%b valid=%b en=%b out=%0d addr=%0d required all 0",
                     pos_ready, sample_valid, mem_en, sample_out, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: pos_ready=%b required 1", pos_ready);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_sample_%0d: sample_valid=%b required 0", c, sample_valid);
            end
            @(negedge clk);
        end
        $display("abort: reset during RD1 handled");
    endtask

    task automatic test_random();
        logic signed [DW-1:0] exp_q [$];
        logic signed [DW-1:0] expv;
        logic signed [DW-1:0] prev_out;
        logic                 prev_stall;
        logic [IW+FW-1:0]     p;
        int                   accepted, delivered, cycle, idx;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = DW'($urandom);
        accepted   = 0;
        delivered  = 0;
        cycle      = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        while (delivered < 1000 && cycle < 40000) begin
            sample_ready = ($urandom % 4) != 0;
            if (accepted < 1000 && ($urandom % 4) != 0) begin
                p = IW'($urandom) == 0 ? '0 : {$urandom};
                case ($urandom % 8)
                    0: p[FW-1:0] = '0;
                    1: p[FW-1:0] = '1;
                    2: p[IW+FW-1:FW] = '1;
                    default: ;
                endcase
                pos_in    = p;
                pos_valid = 1'b1;
            end else begin
                pos_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_out !== prev_out) begin
                    errors++;
                    $display("FAIL rand_hold: valid=%b out=%0d required 1,%0d",
                             sample_valid, sample_out, prev_out);
                end
            end
            if (pos_valid && pos_ready) begin
                idx = int'(pos_in[IW+FW-1:FW]);
                exp_q.push_back(model(int'(mem_model[idx]),
                                      int'(mem_model[(idx + 1) % DEPTH]),
                                      longint'(pos_in[FW-1:0])));
                accepted++;
            end
            if (sample_valid && sample_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected sample_out=%0d", sample_out);
                end else begin
                    expv = exp_q.pop_front();
                    if (sample_out !== expv) begin
                        errors++;
                        $display("FAIL rand_sample_%0d: sample_out=%0d required %0d",
                                 delivered, sample_out, expv);
                    end
                end
                delivered++;
            end
            prev_stall = sample_valid && !sample_ready;
            prev_out   = sample_out;
            @(negedge clk);
            cycle++;
        end
        pos_valid = 1'b0;
        checks++;
        if (delivered != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: delivered=%0d pending=%0d required 1000,0",
                     delivered, exp_q.size());
        end
        $display("random: accepted=%0d delivered=%0d cycles=%0d", accepted, delivered, cycle);
    endtask

    initial begin
        test_reset();
        test_frac_zero();
        test_half();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_frac_interp
